axi_ni_packetizer: RTL and testbench

AXI_NI_PACKETIZER -- requirements
Module: axi_ni_packetizer

---
 rtl/axi_ni_packetizer.sv | 164 ++++++++++++++++
 tb/tb_axi_ni_packetizer.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_ni_packetizer.sv
// AXI slave -> NoC packetizer: turns one accepted AW or AR request into
// a head flit, an address flit and (for writes) LEN+1 data flits.
//
// Ports:
//   ACLK, ARESETn                   clock, async active-low reset
//   IssueWrite / Got_IssueWrite     write request in, one-cycle accept pulse
//   IssueRead  / Got_IssueRead      read request in, one-cycle accept pulse
//   SLAVE_AW* / SLAVE_WADDRREG      write request fields
//   SLAVE_AR* / SLAVE_RADDRREG      read request fields
//   SLAVE_WDATAREG, SLAVE_WVALID    write-data FIFO head and non-empty flag
//   S_INPUT_RE                      pop strobe for the write-data FIFO
//   STOP_WREQ                       high while a packet is in progress
//   FLIT_OUT, FLIT_VALID, FLIT_READY  flit output, valid/ready handshake
module axi_ni_packetizer #(
    parameter logic [3:0] SRC_ID = 4'h0
) (
    input  logic        ACLK,
    input  logic        ARESETn,
    input  logic        IssueWrite,
    output logic        Got_IssueWrite,
    input  logic        IssueRead,
    output logic        Got_IssueRead,
    input  logic [3:0]  SLAVE_AWID,
    input  logic [3:0]  SLAVE_ARID,
    input  logic [31:0] SLAVE_WADDRREG,
    input  logic [31:0] SLAVE_RADDRREG,
    input  logic [3:0]  SLAVE_AWLEN,
    input  logic [3:0]  SLAVE_ARLEN,
    input  logic [2:0]  SLAVE_AWSIZE,
    input  logic [2:0]  SLAVE_ARSIZE,
    input  logic [1:0]  SLAVE_AWBURST,
    input  logic [1:0]  SLAVE_ARBURST,
    input  logic [31:0] SLAVE_WDATAREG,
    input  logic        SLAVE_WVALID,
    output logic        S_INPUT_RE,
    output logic        STOP_WREQ,
    output logic [33:0] FLIT_OUT,
    output logic        FLIT_VALID,
    input  logic        FLIT_READY
);

    typedef enum logic [1:0] {
        IDLE,
        HEAD,
        ADDR,
        DATA
    } state_t;

    localparam logic [1:0] T_HEAD = 2'b00;
    localparam logic [1:0] T_BODY = 2'b01;
    localparam logic [1:0] T_TAIL = 2'b10;

    state_t      state;
    logic        is_wr;
    logic [3:0]  id_q;
    logic [3:0]  len_q;
    logic [31:0] addr_q;
    logic [2:0]  size_q;
    logic [1:0]  burst_q;
    logic [4:0]  beats;
    logic        prio_rd;

    logic        can_load;
    logic        pick_wr;
    logic [31:0] header;

    // Output register may take a new flit if empty or draining this cycle.
    assign can_load = !FLIT_VALID || FLIT_READY;

    assign S_INPUT_RE = (state == DATA) && SLAVE_WVALID && can_load;

    // Under contention the flag picks the side that lost last time.
    assign pick_wr = IssueWrite && (!IssueRead || !prio_rd);

    assign header = {addr_q[31:28], SRC_ID, id_q, len_q, is_wr,
                     size_q, burst_q, 10'd0};

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state          <= IDLE;
            is_wr          <= 1'b0;
            id_q           <= '0;
            len_q          <= '0;
            addr_q         <= '0;
            size_q         <= '0;
            burst_q        <= '0;
            beats          <= '0;
            prio_rd        <= 1'b0;
            Got_IssueWrite <= 1'b0;
            Got_IssueRead  <= 1'b0;
            STOP_WREQ      <= 1'b0;
            FLIT_OUT       <= '0;
            FLIT_VALID     <= 1'b0;
        end else begin
            Got_IssueWrite <= 1'b0;
            Got_IssueRead  <= 1'b0;
            if (FLIT_VALID && FLIT_READY)
                FLIT_VALID <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (IssueWrite || IssueRead) begin
                        if (IssueWrite && IssueRead)
                            prio_rd <= pick_wr;
                        is_wr          <= pick_wr;
                        Got_IssueWrite <= pick_wr;
                        Got_IssueRead  <= !pick_wr;
                        if (pick_wr) begin
                            id_q    <= SLAVE_AWID;
                            addr_q  <= SLAVE_WADDRREG;
                            len_q   <= SLAVE_AWLEN;
                            size_q  <= SLAVE_AWSIZE;
                            burst_q <= SLAVE_AWBURST;
                            beats   <= 5'(SLAVE_AWLEN) + 5'd1;
                        end else begin
                            id_q    <= SLAVE_ARID;
                            addr_q  <= SLAVE_RADDRREG;
                            len_q   <= SLAVE_ARLEN;
                            size_q  <= SLAVE_ARSIZE;
                            burst_q <= SLAVE_ARBURST;
                            beats   <= 5'd0;
                        end
                        STOP_WREQ <= 1'b1;
                        state     <= HEAD;
                    end
                end
                HEAD: begin
                    if (can_load) begin
                        FLIT_OUT   <= {T_HEAD, header};
                        FLIT_VALID <= 1'b1;
                        state      <= ADDR;
                    end
                end
                ADDR: begin
                    if (can_load) begin
                        FLIT_VALID <= 1'b1;
                        if (is_wr) begin
                            FLIT_OUT <= {T_BODY, addr_q};
                            state    <= DATA;
                        end else begin
                            FLIT_OUT  <= {T_TAIL, addr_q};
                            STOP_WREQ <= 1'b0;
                            state     <= IDLE;
                        end
                    end
                end
                DATA: begin
                    if (S_INPUT_RE) begin
                        FLIT_VALID <= 1'b1;
                        beats      <= beats - 5'd1;
                        if (beats == 5'd1) begin
                            FLIT_OUT  <= {T_TAIL, SLAVE_WDATAREG};
                            STOP_WREQ <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            FLIT_OUT <= {T_BODY, SLAVE_WDATAREG};
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_ni_packetizer.sv
// Randomized bench for axi_ni_packetizer with a packet-level model:
// expected flit stream built per request from the header/flit rules.
module tb_axi_ni_packetizer;

    localparam logic [3:0] SRC = 4'h9;

    logic        ACLK;
    logic        ARESETn;
    logic        IssueWrite, IssueRead;
    logic        Got_IssueWrite, Got_IssueRead;
    logic [3:0]  SLAVE_AWID, SLAVE_ARID;
    logic [31:0] SLAVE_WADDRREG, SLAVE_RADDRREG;
    logic [3:0]  SLAVE_AWLEN, SLAVE_ARLEN;
    logic [2:0]  SLAVE_AWSIZE, SLAVE_ARSIZE;
    logic [1:0]  SLAVE_AWBURST, SLAVE_ARBURST;
    logic [31:0] SLAVE_WDATAREG;
    logic        SLAVE_WVALID;
    logic        S_INPUT_RE, STOP_WREQ;
    logic [33:0] FLIT_OUT;
    logic        FLIT_VALID, FLIT_READY;

    axi_ni_packetizer #(.SRC_ID(SRC)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .IssueWrite(IssueWrite), .Got_IssueWrite(Got_IssueWrite),
        .IssueRead(IssueRead), .Got_IssueRead(Got_IssueRead),
        .SLAVE_AWID(SLAVE_AWID), .SLAVE_ARID(SLAVE_ARID),
        .SLAVE_WADDRREG(SLAVE_WADDRREG), .SLAVE_RADDRREG(SLAVE_RADDRREG),
        .SLAVE_AWLEN(SLAVE_AWLEN), .SLAVE_ARLEN(SLAVE_ARLEN),
        .SLAVE_AWSIZE(SLAVE_AWSIZE), .SLAVE_ARSIZE(SLAVE_ARSIZE),
        .SLAVE_AWBURST(SLAVE_AWBURST), .SLAVE_ARBURST(SLAVE_ARBURST),
        .SLAVE_WDATAREG(SLAVE_WDATAREG), .SLAVE_WVALID(SLAVE_WVALID),
        .S_INPUT_RE(S_INPUT_RE), .STOP_WREQ(STOP_WREQ),
        .FLIT_OUT(FLIT_OUT), .FLIT_VALID(FLIT_VALID),
        .FLIT_READY(FLIT_READY)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    int n_chk, n_err;
    logic [33:0] exp_q[$];
    logic [31:0] wfifo[$];
    bit          prio_rd_m;
    int          ready_mode, starve;
    bit          pop_pend, stalled, prev_gw, prev_gr;
    logic [33:0] held;
    int          n_gw, n_gr, n_re, n_flit, cyc;
    int          mark, first_cyc, last_cyc;

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] hdr(logic [31:0] a, logic [3:0] id,
                                        logic [3:0] len, bit wr,
                                        logic [2:0] sz, logic [1:0] bu);
        return {a[31:28], SRC, id, len, wr, sz, bu, 10'd0};
    endfunction

    task automatic set_wr(logic [3:0] id, logic [31:0] a, logic [3:0] len);
        SLAVE_AWID     = id;
        SLAVE_WADDRREG = a;
        SLAVE_AWLEN    = len;
        SLAVE_AWSIZE   = 3'($urandom_range(0, 7));
        SLAVE_AWBURST  = 2'($urandom_range(0, 3));
    endtask

    task automatic set_rd(logic [3:0] id, logic [31:0] a, logic [3:0] len);
        SLAVE_ARID     = id;
        SLAVE_RADDRREG = a;
        SLAVE_ARLEN    = len;
        SLAVE_ARSIZE   = 3'($urandom_range(0, 7));
        SLAVE_ARBURST  = 2'($urandom_range(0, 3));
    endtask

    // Write packet: head, address (body), then LEN+1 data beats.
    task automatic exp_wr(logic [31:0] base);
        logic [31:0] w;
        exp_q.push_back({2'b00, hdr(SLAVE_WADDRREG, SLAVE_AWID, SLAVE_AWLEN,
                                    1'b1, SLAVE_AWSIZE, SLAVE_AWBURST)});
        exp_q.push_back({2'b01, SLAVE_WADDRREG});
        for (int i = 0; i <= int'(SLAVE_AWLEN); i++) begin
            w = base ^ (i * 32'h9E37_79B9);
            wfifo.push_back(w);
            exp_q.push_back({(i == int'(SLAVE_AWLEN)) ? 2'b10 : 2'b01, w});
        end
    endtask

    task automatic exp_rd();
        exp_q.push_back({2'b00, hdr(SLAVE_RADDRREG, SLAVE_ARID, SLAVE_ARLEN,
                                    1'b0, SLAVE_ARSIZE, SLAVE_ARBURST)});
        exp_q.push_back({2'b10, SLAVE_RADDRREG});
    endtask

    task automatic issue_both();
        if (prio_rd_m) begin
            exp_rd();
            exp_wr($urandom);
        end else begin
            exp_wr($urandom);
            exp_rd();
        end
        prio_rd_m  = !prio_rd_m;
        IssueWrite = 1'b1;
        IssueRead  = 1'b1;
    endtask

    task automatic cycle();
        @(negedge ACLK);
        cyc++;
        if (pop_pend) begin
            void'(wfifo.pop_front());
            pop_pend = 1'b0;
        end
        case (ready_mode)
            0: FLIT_READY = 1'b1;
            1: FLIT_READY = ~FLIT_READY;
            default: FLIT_READY = 1'($urandom_range(0, 1));
        endcase
        if (ready_mode == 2 && starve == 0 && $urandom_range(0, 7) == 0)
            starve = $urandom_range(1, 3);
        SLAVE_WVALID   = (starve == 0) && (wfifo.size() > 0);
        SLAVE_WDATAREG = (wfifo.size() > 0) ? wfifo[0] : 32'h0;
        if (starve > 0) starve--;
        #1;
        if (stalled) begin
            chk("stall_valid", 64'(FLIT_VALID), 64'(1));
            chk("stall_flit", 64'(FLIT_OUT), 64'(held));
        end
        stalled = FLIT_VALID && !FLIT_READY;
        held    = FLIT_OUT;
        if (FLIT_VALID && FLIT_READY) begin
            if (n_flit == mark) first_cyc = cyc;
            last_cyc = cyc;
            n_flit++;
            if (exp_q.size() == 0)
                chk("flit_extra", 64'(exp_q.size()), 64'(1));
            else
                chk("flit", 64'(FLIT_OUT), 64'(exp_q.pop_front()));
        end
        if (S_INPUT_RE) begin
            n_re++;
            chk("re_wvalid", 64'(SLAVE_WVALID), 64'(1));
            pop_pend = 1'b1;
        end
        if (Got_IssueWrite) begin
            n_gw++;
            chk("gw_pulse", 64'(prev_gw), 64'(0));
            chk("stop_busy", 64'(STOP_WREQ), 64'(1));
            IssueWrite = 1'b0;
        end
        if (Got_IssueRead) begin
            n_gr++;
            chk("gr_pulse", 64'(prev_gr), 64'(0));
            chk("stop_busy", 64'(STOP_WREQ), 64'(1));
            IssueRead = 1'b0;
        end
        prev_gw = Got_IssueWrite;
        prev_gr = Got_IssueRead;
    endtask

    task automatic wait_idle(int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            cycle();
            done = exp_q.size() == 0 && !IssueWrite && !IssueRead &&
                   !FLIT_VALID && !STOP_WREQ;
        end
        chk("drain", 64'(done), 64'(1));
    endtask

    task automatic clear_model();
        exp_q.delete();
        wfifo.delete();
        prio_rd_m  = 1'b0;
        pop_pend   = 1'b0;
        stalled    = 1'b0;
        starve     = 0;
        IssueWrite = 1'b0;
        IssueRead  = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge ACLK);
        ARESETn = 1'b0;
        clear_model();
        repeat (2) cycle();
        @(negedge ACLK);
        ARESETn = 1'b1;
    endtask

    task automatic chk_outputs_zero(string pfx);
        chk({pfx, "_valid"}, 64'(FLIT_VALID), 64'(0));
        chk({pfx, "_flit"}, 64'(FLIT_OUT), 64'(0));
        chk({pfx, "_gw"}, 64'(Got_IssueWrite), 64'(0));
        chk({pfx, "_gr"}, 64'(Got_IssueRead), 64'(0));
        chk({pfx, "_re"}, 64'(S_INPUT_RE), 64'(0));
        chk({pfx, "_stop"}, 64'(STOP_WREQ), 64'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int gw0, gr0, re0, fl0;
        n_chk = 0; n_err = 0; cyc = 0; mark = -1;
        n_gw = 0; n_gr = 0; n_re = 0; n_flit = 0;
        prev_gw = 0; prev_gr = 0; held = '0;
        ARESETn = 1'b0;
        FLIT_READY = 1'b1;
        ready_mode = 0;
        SLAVE_WVALID = 1'b0;
        SLAVE_WDATAREG = '0;
        set_wr(4'h0, 32'h0, 4'h0);
        set_rd(4'h0, 32'h0, 4'h0);
        clear_model();
        repeat (3) cycle();
        @(negedge ACLK);
        ARESETn = 1'b1;
        #1;
        chk_outputs_zero("reset");

        // Single-beat write at full rate.
        gw0 = n_gw; re0 = n_re; fl0 = n_flit; mark = n_flit;
        set_wr(4'h3, 32'h2000_0040, 4'h0);
        exp_wr(32'hDEAD_BEEF);
        IssueWrite = 1'b1;
        wait_idle(100);
        chk("w1_gw", 64'(n_gw - gw0), 64'(1));
        chk("w1_re", 64'(n_re - re0), 64'(1));
        chk("w1_flits", 64'(n_flit - fl0), 64'(3));
        chk("w1_rate", 64'(last_cyc - first_cyc), 64'(2));

        // Four-beat write with ready toggling.
        ready_mode = 1;
        gw0 = n_gw; re0 = n_re; fl0 = n_flit;
        set_wr(4'hA, 32'h1234_5678, 4'h3);
        exp_wr($urandom);
        IssueWrite = 1'b1;
        wait_idle(200);
        chk("w4_re", 64'(n_re - re0), 64'(4));
        chk("w4_flits", 64'(n_flit - fl0), 64'(6));

        // Read.
        ready_mode = 0;
        gr0 = n_gr; re0 = n_re; fl0 = n_flit;
        set_rd(4'h5, 32'h7000_0000, 4'h7);
        exp_rd();
        IssueRead = 1'b1;
        wait_idle(100);
        chk("rd_gr", 64'(n_gr - gr0), 64'(1));
        chk("rd_re", 64'(n_re - re0), 64'(0));
        chk("rd_flits", 64'(n_flit - fl0), 64'(2));

        // Simultaneous requests out of reset, twice.
        do_reset();
        for (int k = 0; k < 2; k++) begin
            gw0 = n_gw; gr0 = n_gr;
            set_wr(4'($urandom), $urandom, 4'($urandom_range(0, 4)));
            set_rd(4'($urandom), $urandom, 4'($urandom));
            issue_both();
            wait_idle(200);
            chk("both_gw", 64'(n_gw - gw0), 64'(1));
            chk("both_gr", 64'(n_gr - gr0), 64'(1));
        end

        // FIFO starvation mid-burst.
        re0 = n_re; fl0 = n_flit;
        set_wr(4'h6, 32'h4000_0100, 4'h7);
        exp_wr($urandom);
        IssueWrite = 1'b1;
        for (int i = 0; i < 100 && n_re - re0 < 2; i++) cycle();
        starve = 5;
        gw0 = n_re;
        cycle();
        cycle();
        chk("starve_valid", 64'(FLIT_VALID), 64'(0));
        repeat (3) cycle();
        chk("starve_nopop", 64'(n_re - gw0), 64'(0));
        wait_idle(100);
        chk("starve_re", 64'(n_re - re0), 64'(8));
        chk("starve_flits", 64'(n_flit - fl0), 64'(10));

        // Reset in the middle of a burst.
        set_wr(4'h2, 32'h5000_0000, 4'h7);
        exp_wr($urandom);
        IssueWrite = 1'b1;
        re0 = n_re;
        for (int i = 0; i < 100 && n_re - re0 < 3; i++) cycle();
        @(negedge ACLK);
        ARESETn = 1'b0;
        #1;
        chk_outputs_zero("midrst");
        clear_model();
        @(negedge ACLK);
        ARESETn = 1'b1;
        #1;
        chk("midrst_stop", 64'(STOP_WREQ), 64'(0));
        repeat (10) cycle();
        chk("midrst_idle", 64'(FLIT_VALID), 64'(0));

        // Randomized traffic.
        ready_mode = 2;
        for (int t = 0; t < 40; t++) begin
            int kind;
            gw0 = n_gw; gr0 = n_gr;
            kind = $urandom_range(0, 2);
            set_wr(4'($urandom), $urandom, 4'($urandom));
            set_rd(4'($urandom), $urandom, 4'($urandom));
            if (kind == 0) begin
                exp_wr($urandom);
                IssueWrite = 1'b1;
            end else if (kind == 1) begin
                exp_rd();
                IssueRead = 1'b1;
            end else begin
                issue_both();
            end
            wait_idle(800);
            chk("rnd_gw", 64'(n_gw - gw0), 64'(kind != 1));
            chk("rnd_gr", 64'(n_gr - gr0), 64'(kind != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

endmodule
